// File: rtl/fdiv_if.sv
// Operand/result handshake bundle for the fdiv iterative binary32 divider.
// master: operand producer and result consumer; slave: the divider.
interface fdiv_if;
    logic [31:0] s;
    logic [31:0] t;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output s, t, in_valid, out_ready,
        input  in_ready, d, overflow, underflow, div_by_zero, out_valid
    );

    modport slave (
        input  s, t, in_valid, out_ready,
        output in_ready, d, overflow, underflow, div_by_zero, out_valid
    );
endinterface

// File: rtl/fdiv.sv
// Iterative binary32 divider d = s / t: 26-step restoring division, RNE rounding.
// Optional FDIV_EARLY_OUT_EN: special cases and exponent saturation finish one cycle after accept.
module fdiv (
    input  logic   clk,
    input  logic   rst,
    fdiv_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int Q_W    = 26;
    localparam int EXP_W  = 10;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    state_t state, state_nxt;

    logic                    accept, handshake, early;
    logic                    sign_s, sign_t, sign_q;
    logic [7:0]              es, et;
    logic [22:0]             fs, ft;
    logic                    s_zero, s_inf, s_nan, t_zero, t_inf, t_nan;
    logic                    sp_hit, sp_dbz;
    logic [DATA_W-1:0]       sp_d;
    logic [23:0]             ma, mb;
    logic                    adj;
    logic signed [EXP_W-1:0] e_pre, e_in;
    logic [Q_W-1:0]          rem_in;

    logic                    sign_p0, sp_p0, sp_dbz_p0;
    logic [DATA_W-1:0]       sp_d_p0;
    logic signed [EXP_W-1:0] exp_p0;
    logic [23:0]             mb_p0;
    logic [Q_W-1:0]          rem_p0, q_p0, rem_sub, rem_nxt;
    logic                    q_bit;
    logic [4:0]              cnt_p0;

    logic [DATA_W-1:0]       d_p1;
    logic                    ovf_p1, unf_p1, dbz_p1;

    // Round-to-nearest-even on the 26-bit quotient, then saturate or flush the exponent.
    function automatic logic [DATA_W+1:0] round_pack(
        input logic                    sign,
        input logic signed [EXP_W-1:0] e,
        input logic [Q_W-1:0]          q,
        input logic                    sticky
    );
        logic                    inc;
        logic [24:0]             sig;
        logic signed [EXP_W-1:0] e_rnd;
        logic [DATA_W-1:0]       res;
        logic                    ovf, unf;
        inc   = q[1] & (q[0] | sticky | q[2]);
        sig   = {1'b0, q[25:2]} + {24'd0, inc};
        e_rnd = sig[24] ? e + 10'sd1 : e;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (e_rnd >= 10'sd255) begin
            res = {sign, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (e_rnd <= 10'sd0) begin
            res = {sign, 31'd0};
            unf = 1'b1;
        end else begin
            res = {sign, e_rnd[7:0], sig[22:0]};
        end
        return {ovf, unf, res};
    endfunction

    assign accept    = bus.in_valid && (state == IDLE);
    assign handshake = bus.out_ready && (state == DONE);

    assign sign_s = bus.s[31];
    assign sign_t = bus.t[31];
    assign es     = bus.s[30:23];
    assign et     = bus.t[30:23];
    assign fs     = bus.s[22:0];
    assign ft     = bus.t[22:0];
    assign sign_q = sign_s ^ sign_t;

    // Subnormal operands count as zero.
    assign s_zero = (es == 8'd0);
    assign t_zero = (et == 8'd0);
    assign s_inf  = (es == 8'hFF) && (fs == 23'd0);
    assign t_inf  = (et == 8'hFF) && (ft == 23'd0);
    assign s_nan  = (es == 8'hFF) && (fs != 23'd0);
    assign t_nan  = (et == 8'hFF) && (ft != 23'd0);

    always_comb begin
        sp_hit = 1'b1;
        sp_dbz = 1'b0;
        sp_d   = '0;
        if (s_nan)                                    sp_d = bus.s | 32'h0040_0000;
        else if (t_nan)                               sp_d = bus.t | 32'h0040_0000;
        else if ((s_zero && t_zero) || (s_inf && t_inf)) sp_d = 32'h7FC0_0000;
        else if (s_inf)                               sp_d = {sign_q, 8'hFF, 23'd0};
        else if (t_inf)                               sp_d = {sign_q, 31'd0};
        else if (s_zero)                              sp_d = {sign_q, 31'd0};
        else if (t_zero) begin
            sp_d   = {sign_q, 8'hFF, 23'd0};
            sp_dbz = 1'b1;
        end else begin
            sp_hit = 1'b0;
        end
    end

    assign ma     = {1'b1, fs};
    assign mb     = {1'b1, ft};
    assign adj    = (ma < mb);
    assign rem_in = adj ? {1'b0, ma, 1'b0} : {2'b00, ma};
    assign e_pre  = $signed({2'b00, es}) - $signed({2'b00, et}) + 10'sd127;
    assign e_in   = e_pre - $signed({9'd0, adj});

`ifdef FDIV_EARLY_OUT_EN
    logic eo_ovf, eo_unf;
    assign eo_ovf = !sp_hit && (e_pre >= 10'sd256);
    assign eo_unf = !sp_hit && (e_pre < 10'sd0);
    assign early  = sp_hit || eo_ovf || eo_unf;
`else
    assign early  = 1'b0;
`endif

    assign q_bit   = (rem_p0 >= {2'b00, mb_p0});
    assign rem_sub = q_bit ? rem_p0 - {2'b00, mb_p0} : rem_p0;
    assign rem_nxt = {rem_sub[Q_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_p0 <= '0;
        end else begin
            state <= state_nxt;
            if (accept)             cnt_p0 <= '0;
            else if (state == DIV)  cnt_p0 <= cnt_p0 + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = early ? DONE : DIV;
            DIV:     if (cnt_p0 == 5'd25) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: operands captured at accept, then one quotient bit per DIV cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_p0   <= sign_q;
            exp_p0    <= e_in;
            mb_p0     <= mb;
            rem_p0    <= rem_in;
            q_p0      <= '0;
            sp_p0     <= sp_hit;
            sp_d_p0   <= sp_d;
            sp_dbz_p0 <= sp_dbz;
        end else if (state == DIV) begin
            rem_p0 <= rem_nxt;
            q_p0   <= {q_p0[Q_W-2:0], q_bit};
        end
    end

    // Stage p1: registered result and flags, held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_p1   <= '0;
            ovf_p1 <= 1'b0;
            unf_p1 <= 1'b0;
            dbz_p1 <= 1'b0;
        end else if (accept) begin
            ovf_p1 <= 1'b0;
            unf_p1 <= 1'b0;
            dbz_p1 <= 1'b0;
`ifdef FDIV_EARLY_OUT_EN
            if (sp_hit) begin
                d_p1   <= sp_d;
                dbz_p1 <= sp_dbz;
            end else if (eo_ovf) begin
                d_p1   <= {sign_q, 8'hFF, 23'd0};
                ovf_p1 <= 1'b1;
            end else if (eo_unf) begin
                d_p1   <= {sign_q, 31'd0};
                unf_p1 <= 1'b1;
            end
`endif
        end else if (state == ROUND) begin
            if (sp_p0) begin
                d_p1   <= sp_d_p0;
                dbz_p1 <= sp_dbz_p0;
            end else begin
                {ovf_p1, unf_p1, d_p1} <= round_pack(sign_p0, exp_p0, q_p0, rem_p0 != '0);
            end
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.d           = d_p1;
    assign bus.overflow    = ovf_p1;
    assign bus.underflow   = unf_p1;
    assign bus.div_by_zero = dbz_p1;
endmodule
